ir_scan_scheduler: RTL and testbench

Time-multiplexes the single IR ADC across the right, forward and left IR sensors on a fixed scan period. Each conversion is low-pass filtered per channel, and the block presents `right_ir`, `left_ir` and the thresholded `forward_ir` to `navigation_fsm`. It sits between the ADC interface and the navigation state machine and owns all ADC sequencing.

---
 rtl/nav_pkg.sv | 22 ++
 rtl/ir_lpf_update.sv | 31 +++
 rtl/ir_scan_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_ir_scan_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// Shared navigation types: IR channel encoding, scan FSM states and datapath widths.
// Used by ir_scan_scheduler and navigation_fsm.
package nav_pkg;

    localparam int unsigned IR_W  = 16;   // filtered IR level width
    localparam int unsigned ADC_W = 12;   // raw ADC result width

    typedef enum logic [1:0] {
        IR_RIGHT   = 2'd0,
        IR_FORWARD = 2'd1,
        IR_LEFT    = 2'd2
    } ir_chan_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } scan_state_t;

endpackage

// File: rtl/ir_lpf_update.sv
// One-pole IIR step for a single IR channel: y_next = y + ((x - y) >>> FILT_SHIFT).
// An unseeded channel loads x directly so the first sample is not dragged up from zero.
// Ports:
//   x_i       new sample, zero-extended ADC result
//   y_i       current filter state
//   seeded_i  channel has already taken a sample since reset
//   y_next_o  next filter state
module ir_lpf_update
    import nav_pkg::*;
#(
    parameter int unsigned FILT_SHIFT = 2
) (
    input  logic [IR_W-1:0] x_i,
    input  logic [IR_W-1:0] y_i,
    input  logic            seeded_i,
    output logic [IR_W-1:0] y_next_o
);

    logic signed [IR_W:0] diff;
    logic signed [IR_W:0] step;
    logic signed [IR_W:0] sum;

    // Signed 17-bit difference keeps the arithmetic shift rounding toward -inf on decay.
    always_comb begin
        diff     = $signed({1'b0, x_i}) - $signed({1'b0, y_i});
        step     = diff >>> FILT_SHIFT;
        sum      = $signed({1'b0, y_i}) + step;
        y_next_o = seeded_i ? sum[IR_W-1:0] : x_i;
    end

endmodule

// File: rtl/ir_scan_scheduler.sv
// Periodically sequences the shared IR ADC over right, forward and left sensors,
// low-pass filters each result and applies hysteresis to the forward level.
// Ports:
//   clk_in, reset_in         clock, asynchronous active-high reset
//   scan_en                  enables periodic scanning
//   adc_start, adc_channel   conversion request pulse and channel select
//   adc_done, adc_data       conversion-complete strobe and result
//   right_ir, left_ir,
//   forward_level            filtered levels, updated at the end of UPDATE
//   forward_ir               forward level with hysteresis
//   scan_valid               pulse while in DONE
//   adc_timeout              pulse on the WAIT cycle that abandons a conversion
//   scan_overrun             pulse on the cycle a period tick is dropped
module ir_scan_scheduler
    import nav_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD = 50000,
    parameter int unsigned ADC_TIMEOUT = 256,
    parameter int unsigned FILT_SHIFT  = 2,
    parameter int unsigned FWD_HI      = 1200,
    parameter int unsigned FWD_LO      = 1000
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             scan_en,
    output logic             adc_start,
    output logic [1:0]       adc_channel,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic [IR_W-1:0]  right_ir,
    output logic [IR_W-1:0]  left_ir,
    output logic [IR_W-1:0]  forward_level,
    output logic             forward_ir,
    output logic             scan_valid,
    output logic             adc_timeout,
    output logic             scan_overrun
);

    localparam int unsigned PER_W = $clog2(SCAN_PERIOD);
    localparam int unsigned TMO_W = $clog2(ADC_TIMEOUT + 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SCAN_PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ADC_TIMEOUT - 1);

    scan_state_t      state_q;
    ir_chan_t         chan_q;
    logic [PER_W-1:0] per_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [ADC_W-1:0] data_q;
    logic [IR_W-1:0]  right_q, fwd_q, left_q;
    logic [2:0]       seeded_q;
    logic             fwd_ir_q, adc_start_q, scan_valid_q;

    logic             tick;
    logic             tmo_hit;
    logic [IR_W-1:0]  y_sel;
    logic             seeded_sel;
    logic [IR_W-1:0]  y_next_d;

    assign tick    = scan_en && (per_cnt_q == PER_LAST);
    // adc_done in the same cycle as the last timeout count takes priority.
    assign tmo_hit = (state_q == ST_WAIT) && !adc_done && (tmo_cnt_q == TMO_LAST);

    // Period counter: parked at zero while scanning is disabled.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            per_cnt_q <= '0;
        end else if (!scan_en || per_cnt_q == PER_LAST) begin
            per_cnt_q <= '0;
        end else begin
            per_cnt_q <= PER_W'(per_cnt_q + 1'b1);
        end
    end

    // Single filter datapath shared by all three channels.
    always_comb begin
        y_sel      = right_q;
        seeded_sel = seeded_q[0];
        case (chan_q)
            IR_FORWARD: begin
                y_sel      = fwd_q;
                seeded_sel = seeded_q[1];
            end
            IR_LEFT: begin
                y_sel      = left_q;
                seeded_sel = seeded_q[2];
            end
            default: ;
        endcase
    end

    ir_lpf_update #(
        .FILT_SHIFT (FILT_SHIFT)
    ) u_lpf (
        .x_i      (IR_W'(data_q)),
        .y_i      (y_sel),
        .seeded_i (seeded_sel),
        .y_next_o (y_next_d)
    );

    // Scan sequencer with registered request/valid outputs and filter state.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= ST_IDLE;
            chan_q       <= IR_RIGHT;
            tmo_cnt_q    <= '0;
            data_q       <= '0;
            right_q      <= '0;
            fwd_q        <= '0;
            left_q       <= '0;
            seeded_q     <= '0;
            fwd_ir_q     <= 1'b0;
            adc_start_q  <= 1'b0;
            scan_valid_q <= 1'b0;
        end else begin
            adc_start_q  <= 1'b0;
            scan_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_q     <= ST_START;
                        chan_q      <= IR_RIGHT;
                        adc_start_q <= 1'b1;
                    end
                end
                ST_START: begin
                    state_q   <= ST_WAIT;
                    tmo_cnt_q <= '0;
                end
                ST_WAIT: begin
                    if (adc_done) begin
                        data_q  <= adc_data;
                        state_q <= ST_UPDATE;
                    end else if (tmo_hit) begin
                        if (chan_q == IR_LEFT) begin
                            state_q      <= ST_DONE;
                            scan_valid_q <= 1'b1;
                        end else begin
                            state_q     <= ST_START;
                            chan_q      <= ir_chan_t'(chan_q + 2'd1);
                            adc_start_q <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_q <= TMO_W'(tmo_cnt_q + 1'b1);
                    end
                end
                ST_UPDATE: begin
                    case (chan_q)
                        IR_FORWARD: begin
                            fwd_q       <= y_next_d;
                            seeded_q[1] <= 1'b1;
                            if (y_next_d > IR_W'(FWD_HI)) begin
                                fwd_ir_q <= 1'b1;
                            end else if (y_next_d < IR_W'(FWD_LO)) begin
                                fwd_ir_q <= 1'b0;
                            end
                        end
                        IR_LEFT: begin
                            left_q      <= y_next_d;
                            seeded_q[2] <= 1'b1;
                        end
                        default: begin
                            right_q     <= y_next_d;
                            seeded_q[0] <= 1'b1;
                        end
                    endcase
                    if (chan_q == IR_LEFT) begin
                        state_q      <= ST_DONE;
                        scan_valid_q <= 1'b1;
                    end else begin
                        state_q     <= ST_START;
                        chan_q      <= ir_chan_t'(chan_q + 2'd1);
                        adc_start_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign adc_start     = adc_start_q;
    assign adc_channel   = chan_q;
    assign scan_valid    = scan_valid_q;
    assign right_ir      = right_q;
    assign left_ir       = left_q;
    assign forward_level = fwd_q;
    assign forward_ir    = fwd_ir_q;
    assign adc_timeout   = tmo_hit;
    // A tick that lands outside IDLE is discarded.
    assign scan_overrun  = tick && (state_q != ST_IDLE);

endmodule

// File: tb/tb_ir_scan_scheduler.sv
// Directed bench for ir_scan_scheduler with a behavioural ADC that answers after w cycles.
module tb_ir_scan_scheduler;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        scan_en;
    logic        adc_start;
    logic [1:0]  adc_channel;
    logic        adc_done;
    logic [11:0] adc_data;
    logic [15:0] right_ir;
    logic [15:0] left_ir;
    logic [15:0] forward_level;
    logic        forward_ir;
    logic        scan_valid;
    logic        adc_timeout;
    logic        scan_overrun;

    always #5 clk_in = ~clk_in;

    ir_scan_scheduler #(
        .SCAN_PERIOD (16),
        .ADC_TIMEOUT (8),
        .FILT_SHIFT  (2),
        .FWD_HI      (1200),
        .FWD_LO      (1000)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .scan_en       (scan_en),
        .adc_start     (adc_start),
        .adc_channel   (adc_channel),
        .adc_done      (adc_done),
        .adc_data      (adc_data),
        .right_ir      (right_ir),
        .left_ir       (left_ir),
        .forward_level (forward_level),
        .forward_ir    (forward_ir),
        .scan_valid    (scan_valid),
        .adc_timeout   (adc_timeout),
        .scan_overrun  (scan_overrun)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // ADC model configuration and state
    int          wcfg[3];
    logic [11:0] dcfg[3];
    bit          ans[3];
    bit          pend;
    int          wcnt;
    int          pend_w;
    logic [11:0] pend_data;

    // Observations
    int          ncyc = 0;
    int          nstart, nvalid, ntmo, novr;
    int          stc[3];
    int          chl[3];
    int          last_st, vcyc, tmo_cyc, ovr_cyc;
    logic [15:0] v_right, v_fwd, v_left;
    logic        v_fir;
    int          rise;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        nstart  = 0;
        nvalid  = 0;
        ntmo    = 0;
        novr    = 0;
        stc     = '{-1, -1, -1};
        chl     = '{-1, -1, -1};
        last_st = -1;
        vcyc    = -1;
        tmo_cyc = -1;
        ovr_cyc = -1;
    endtask

    // One clock: drive ADC response at negedge, then sample outputs 1 time unit later.
    task automatic step();
        @(negedge clk_in);
        ncyc++;
        adc_done = 1'b0;
        if (pend) begin
            wcnt++;
            if (wcnt == pend_w) begin
                adc_done = 1'b1;
                adc_data = pend_data;
                pend     = 1'b0;
            end
        end
        #1;
        if (adc_start) begin
            if (nstart < 3) begin
                stc[nstart] = ncyc;
                chl[nstart] = int'(adc_channel);
            end
            nstart++;
            last_st   = ncyc;
            pend      = ans[int'(adc_channel)];
            pend_w    = wcfg[int'(adc_channel)];
            pend_data = dcfg[int'(adc_channel)];
            wcnt      = 0;
        end
        if (scan_valid) begin
            nvalid++;
            vcyc    = ncyc;
            v_right = right_ir;
            v_fwd   = forward_level;
            v_left  = left_ir;
            v_fir   = forward_ir;
        end
        if (adc_timeout) begin
            ntmo++;
            tmo_cyc = ncyc;
        end
        if (scan_overrun) begin
            novr++;
            ovr_cyc = ncyc;
        end
    endtask

    // Raise scan_en for one tick, drop it after the first START, run the scan to IDLE.
    task automatic run_scan(input int w, input logic [11:0] d0, input logic [11:0] d1,
                            input logic [11:0] d2, input bit a1);
        clear_stats();
        wcfg    = '{w, w, w};
        dcfg    = '{d0, d1, d2};
        ans     = '{1'b1, a1, 1'b1};
        scan_en = 1'b1;
        rise    = ncyc;
        for (int i = 0; i < 40 && nstart == 0; i++) step();
        scan_en = 1'b0;
        for (int i = 0; i < 120 && nvalid == 0; i++) step();
        step();
        chk("first_start_delay", 32'(stc[0] - rise), 32'd16);
        chk("scan_valid_count", 32'(nvalid), 32'd1);
    endtask

    initial begin
        reset_in = 1'b1;
        scan_en  = 1'b0;
        adc_done = 1'b0;
        adc_data = 12'd0;
        pend     = 1'b0;
        clear_stats();

        // Reset state
        step();
        step();
        chk("rst_right", 32'(right_ir), 32'd0);
        chk("rst_left", 32'(left_ir), 32'd0);
        chk("rst_fwd", 32'(forward_level), 32'd0);
        chk("rst_fwd_ir", 32'(forward_ir), 32'd0);
        chk("rst_start", 32'(adc_start), 32'd0);
        chk("rst_valid", 32'(scan_valid), 32'd0);
        reset_in = 1'b0;
        step();
        step();

        // Basic scan: seeded loads, channel order, 17-cycle latency incl. tick and DONE
        run_scan(3, 12'd800, 12'd1500, 12'd400, 1'b1);
        chk("basic_ch0", 32'(chl[0]), 32'd0);
        chk("basic_ch1", 32'(chl[1]), 32'd1);
        chk("basic_ch2", 32'(chl[2]), 32'd2);
        chk("basic_latency", 32'(vcyc - stc[0] + 2), 32'd17);
        chk("basic_right", 32'(v_right), 32'd800);
        chk("basic_fwd", 32'(v_fwd), 32'd1500);
        chk("basic_fwd_ir", 32'(v_fir), 32'd1);
        chk("basic_left", 32'(v_left), 32'd400);
        chk("basic_no_tmo", 32'(ntmo), 32'd0);

        // Filter step toward zero on the right channel
        run_scan(3, 12'd0, 12'd1500, 12'd400, 1'b1);
        chk("filt_right_1", 32'(v_right), 32'd600);
        chk("filt_fwd_1", 32'(v_fwd), 32'd1500);
        run_scan(3, 12'd0, 12'd1500, 12'd400, 1'b1);
        chk("filt_right_2", 32'(v_right), 32'd450);
        chk("filt_left_2", 32'(v_left), 32'd400);

        // Forward channel never answers
        run_scan(1, 12'd450, 12'd0, 12'd400, 1'b0);
        chk("tmo_count", 32'(ntmo), 32'd1);
        chk("tmo_offset", 32'(tmo_cyc - stc[1]), 32'd8);
        chk("tmo_next_start", 32'(stc[2] - stc[1]), 32'd9);
        chk("tmo_ch2", 32'(chl[2]), 32'd2);
        chk("tmo_fwd_kept", 32'(v_fwd), 32'd1500);
        chk("tmo_right", 32'(v_right), 32'd450);

        // Overrun: period 16 with w=5 (23-cycle scan)
        clear_stats();
        wcfg    = '{5, 5, 5};
        dcfg    = '{12'd450, 12'd1500, 12'd400};
        ans     = '{1'b1, 1'b1, 1'b1};
        scan_en = 1'b1;
        rise    = ncyc;
        for (int i = 0; i < 47; i++) step();
        chk("ovr_count", 32'(novr), 32'd1);
        chk("ovr_cycle", 32'(ovr_cyc - rise), 32'd31);
        chk("ovr_starts", 32'(nstart), 32'd3);
        chk("ovr_valid_cycle", 32'(vcyc - rise), 32'd37);
        step();
        chk("ovr_next_start", 32'(last_st - rise), 32'd48);
        scan_en = 1'b0;
        for (int i = 0; i < 60 && nvalid < 2; i++) step();
        step();
        chk("ovr_second_valid", 32'(nvalid), 32'd2);

        // Asynchronous reset while waiting on the ADC
        clear_stats();
        wcfg    = '{3, 3, 3};
        scan_en = 1'b1;
        for (int i = 0; i < 40 && nstart == 0; i++) step();
        scan_en = 1'b0;
        step();
        reset_in = 1'b1;
        #1;
        chk("arst_right", 32'(right_ir), 32'd0);
        chk("arst_left", 32'(left_ir), 32'd0);
        chk("arst_fwd", 32'(forward_level), 32'd0);
        chk("arst_fwd_ir", 32'(forward_ir), 32'd0);
        chk("arst_channel", 32'(adc_channel), 32'd0);
        pend = 1'b0;
        step();
        step();
        reset_in = 1'b0;
        step();

        // Reseeded after reset, then hysteresis: levels 1100, 1300, 1100, 900
        run_scan(1, 12'd200, 12'd1100, 12'd300, 1'b1);
        chk("reseed_right", 32'(v_right), 32'd200);
        chk("hys_fwd_1100a", 32'(v_fwd), 32'd1100);
        chk("hys_ir_0a", 32'(v_fir), 32'd0);
        run_scan(1, 12'd200, 12'd1900, 12'd300, 1'b1);
        chk("hys_fwd_1300", 32'(v_fwd), 32'd1300);
        chk("hys_ir_1a", 32'(v_fir), 32'd1);
        run_scan(1, 12'd200, 12'd500, 12'd300, 1'b1);
        chk("hys_fwd_1100b", 32'(v_fwd), 32'd1100);
        chk("hys_ir_1b", 32'(v_fir), 32'd1);
        run_scan(1, 12'd200, 12'd300, 12'd300, 1'b1);
        chk("hys_fwd_900", 32'(v_fwd), 32'd900);
        chk("hys_ir_0b", 32'(v_fir), 32'd0);
        chk("hys_left", 32'(v_left), 32'd300);

        // Stray adc_done while idle
        clear_stats();
        @(negedge clk_in);
        adc_done = 1'b1;
        adc_data = 12'd4000;
        for (int i = 0; i < 6; i++) step();
        chk("idle_done_right", 32'(right_ir), 32'd200);
        chk("idle_done_fwd", 32'(forward_level), 32'd900);
        chk("idle_done_left", 32'(left_ir), 32'd300);
        chk("idle_done_fwd_ir", 32'(forward_ir), 32'd0);
        chk("idle_done_starts", 32'(nstart), 32'd0);
        chk("idle_done_valid", 32'(nvalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
